// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// op encodings, FSM state type and small arithmetic helpers.
package mdu_pkg;

  localparam int MAX_XLEN = 64;

  // {w, funct3} op encodings
  localparam logic [3:0] OP_MUL    = 4'b0000;
  localparam logic [3:0] OP_MULH   = 4'b0001;
  localparam logic [3:0] OP_MULHSU = 4'b0010;
  localparam logic [3:0] OP_MULHU  = 4'b0011;
  localparam logic [3:0] OP_DIV    = 4'b0100;
  localparam logic [3:0] OP_DIVU   = 4'b0101;
  localparam logic [3:0] OP_REM    = 4'b0110;
  localparam logic [3:0] OP_REMU   = 4'b0111;
  localparam logic [3:0] OP_MULW   = 4'b1000;
  localparam logic [3:0] OP_DIVW   = 4'b1100;
  localparam logic [3:0] OP_DIVUW  = 4'b1101;
  localparam logic [3:0] OP_REMW   = 4'b1110;
  localparam logic [3:0] OP_REMUW  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MAX_XLEN-32){v[31]}}, v};
  endfunction

  // Two's-complement negate at full double-width product size
  function automatic logic [2*MAX_XLEN-1:0] negate(input logic [2*MAX_XLEN-1:0] v);
    return (~v) + (2*MAX_XLEN)'(1);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider over unsigned magnitudes, one quotient bit per
// cycle; w selects a 32-bit division inside the XLEN-wide datapath.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic            w,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic            running_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   last_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;

  // One restoring step; quotient/remainder present the post-step values so the
  // caller can capture the final result on the same edge that done is high.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    fits   = !diff[XLEN];
    rem_nx = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx = {quo_q[XLEN-2:0], fits};
  end

  assign done      = running_q && (cnt_q == last_q);
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
    end else if (running_q) begin
      if (cnt_q == last_q) running_q <= 1'b0;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A 32-bit dividend is pre-aligned to the top so its MSB is shifted out first.
  always_ff @(posedge clk) begin
    if (start) begin
      rem_q  <= '0;
      quo_q  <= w ? (dividend << (XLEN - 32)) : dividend;
      dvs_q  <= divisor;
      last_q <= w ? CW'(31) : CW'(XLEN - 1);
    end else if (running_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide execution unit for RV32M/RV64M with valid/ready
// handshakes; shift-add multiplier inline, restoring divider in mdu_divider.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN               = 64,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int K  = MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(XLEN + 1);

  state_e state_q, state_d;

  function automatic logic [XLEN-1:0] fmt_w(input logic w, input logic [XLEN-1:0] v);
    logic [MAX_XLEN-1:0] ext;
    ext = sext32(v[31:0]);
    return w ? ext[XLEN-1:0] : v;
  endfunction

  // ---------------- request decode (accept cycle) ----------------
  logic            op_w, is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic [2:0]      f3;
  logic [31:0]     a_mag32, b_mag32;
  logic [XLEN-1:0] a_n, b_n, mag_a, mag_b, spec_raw;
  logic            b_zero, a_min, b_m1, div_ovf, special, res_neg_in;
  logic [CW-1:0]   mul_last;
  logic            accept;

  // NOTE: every always_comb output gets a value on every path; a missed
  // assignment would infer a latch.
  always_comb begin
    op_w     = (XLEN == 64) ? in_op[3] : 1'b0;
    f3       = in_op[2:0];
    is_div   = f3[2];
    sgn_a    = is_div ? !f3[0] : (f3[1:0] != 2'b11);
    sgn_b    = is_div ? !f3[0] : !f3[1];
    a_n      = op_w ? XLEN'(in_a[31:0]) : in_a;
    b_n      = op_w ? XLEN'(in_b[31:0]) : in_b;
    a_neg    = sgn_a && (op_w ? in_a[31] : in_a[XLEN-1]);
    b_neg    = sgn_b && (op_w ? in_b[31] : in_b[XLEN-1]);
    a_mag32  = -in_a[31:0];
    b_mag32  = -in_b[31:0];
    mag_a    = a_neg ? (op_w ? XLEN'(a_mag32) : -in_a) : a_n;
    mag_b    = b_neg ? (op_w ? XLEN'(b_mag32) : -in_b) : b_n;
    b_zero   = (b_n == '0);
    a_min    = op_w ? (in_a[31:0] == 32'h8000_0000)
                    : (in_a == {1'b1, {(XLEN-1){1'b0}}});
    b_m1     = op_w ? (in_b[31:0] == 32'hFFFF_FFFF) : (in_b == '1);
    div_ovf  = is_div && !f3[0] && a_min && b_m1;
    special  = is_div && (b_zero || div_ovf);
    // Divide-by-zero wins over overflow: b == 0 can never also be -1.
    if (b_zero) spec_raw = f3[1] ? a_n : '1;
    else        spec_raw = f3[1] ? '0  : a_n;
    // Remainders follow the dividend; quotients and products the sign XOR.
    res_neg_in = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
    mul_last   = op_w ? CW'(32 / K - 1) : CW'(XLEN / K - 1);
  end

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

  // ---------------- latched op and multiplier datapath ----------------
  logic              w_q, is_div_q, want_rem_q, sel_high_q, res_neg_q;
  logic [CW-1:0]     cnt_q, last_q;
  logic [2*XLEN-1:0] acc_q, mcand_q, acc_nx;
  logic [XLEN-1:0]   mplr_q;

  always_comb begin
    acc_nx = acc_q;
    for (int i = 0; i < K; i++) begin
      if (mplr_q[i]) acc_nx = acc_nx + (mcand_q << i);
    end
  end

  logic [2*MAX_XLEN-1:0] prod_wide, prod_fix;
  logic [XLEN-1:0]       mul_res;

  always_comb begin
    prod_wide                = '0;
    prod_wide[2*XLEN-1:0]    = acc_nx;
    prod_fix                 = res_neg_q ? negate(prod_wide) : prod_wide;
    if (!sel_high_q)  mul_res = prod_fix[XLEN-1:0];
    else if (w_q)     mul_res = XLEN'(prod_fix[63:32]);
    else              mul_res = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------- divider ----------------
  logic            div_done;
  logic [XLEN-1:0] div_quo, div_rem, div_raw, div_fixed;

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div && !special),
    .kill      (flush),
    .w         (op_w),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    div_raw   = want_rem_q ? div_rem : div_quo;
    div_fixed = res_neg_q ? -div_raw : div_raw;
  end

  // ---------------- FSM and result register ----------------
  logic            calc_done, res_load;
  logic [XLEN-1:0] res_d;

  assign calc_done = is_div_q ? div_done : (cnt_q == last_q);

  always_comb begin
    state_d  = state_q;
    res_load = 1'b0;
    res_d    = '0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = special ? ST_DONE : ST_CALC;
        if (special) begin
          res_load = 1'b1;
          res_d    = fmt_w(op_w, spec_raw);
        end
      end
      ST_CALC: if (calc_done) begin
        state_d  = ST_DONE;
        res_load = 1'b1;
        res_d    = fmt_w(w_q, is_div_q ? div_fixed : mul_res);
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      res_load = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_result <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (res_load) out_result <= res_d;
      if (accept)                    cnt_q <= '0;
      else if (state_q == ST_CALC)   cnt_q <= cnt_q + CW'(1);
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded on
  // accept before the FSM ever looks at them.
  always_ff @(posedge clk) begin
    if (accept) begin
      w_q        <= op_w;
      is_div_q   <= is_div;
      want_rem_q <= f3[1];
      sel_high_q <= (f3[1:0] != 2'b00);
      res_neg_q  <= res_neg_in;
      last_q     <= mul_last;
      acc_q      <= '0;
      mcand_q    <= {{XLEN{1'b0}}, mag_a};
      mplr_q     <= mag_b;
    end else if (state_q == ST_CALC) begin
      acc_q   <= acc_nx;
      mcand_q <= mcand_q << K;
      mplr_q  <= mplr_q >> K;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: two instances (1 and 4 multiplier bits per
// cycle) share stimulus; results come from a plain-arithmetic reference model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [3:0]  in_op;
  logic [63:0] in_a, in_b;

  logic        in_ready1, out_valid1, busy1;
  logic [63:0] out_result1;
  logic        in_ready4, out_valid4, busy4;
  logic [63:0] out_result4;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(64), .MUL_BITS_PER_CYCLE(1)) u_k1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid1),
    .out_ready(out_ready), .out_result(out_result1), .busy(busy1)
  );

  mdu_iter #(.XLEN(64), .MUL_BITS_PER_CYCLE(4)) u_k4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid4),
    .out_ready(out_ready), .out_result(out_result4), .busy(busy4)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics with wide signed arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    int          a32, b32;
    longint      a64, b64;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r64;
    if (!op[2]) begin
      if (op[3]) begin
        pa = $signed(a[31:0]);
        pb = $signed(b[31:0]);
        p  = pa * pb;
        return {{32{p[31]}}, p[31:0]};
      end
      if (op[1:0] == 2'b11) pa = {64'b0, a}; else pa = $signed(a);
      if (op[1])            pb = {64'b0, b}; else pb = $signed(b);
      p = pa * pb;
      return (op[1:0] == 2'b00) ? p[63:0] : p[127:64];
    end
    if (op[3]) begin
      ua32 = a[31:0]; ub32 = b[31:0]; a32 = a[31:0]; b32 = b[31:0];
      if (ub32 == 0)                 r32 = op[1] ? ua32 : 32'hFFFF_FFFF;
      else if (!op[0]) begin
        if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : ua32;
        else r32 = op[1] ? a32 % b32 : a32 / b32;
      end else                       r32 = op[1] ? ua32 % ub32 : ua32 / ub32;
      return {{32{r32[31]}}, r32};
    end
    a64 = a; b64 = b;
    if (b == 0)                      r64 = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!op[0]) begin
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = op[1] ? 64'h0 : a;
      else r64 = op[1] ? a64 % b64 : a64 / b64;
    end else                         r64 = op[1] ? a % b : a / b;
    return r64;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input int k);
    int n;
    n = op[3] ? 32 : 64;
    if (!op[2]) return n / k + 1;
    if (op[3] ? (b[31:0] == 0) : (b == 0)) return 1;
    if (!op[0] && (op[3] ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
    return n + 1;
  endfunction

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(in_ready1 && in_ready4) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " idle"}, {63'b0, in_ready1 && in_ready4}, 64'd1);
  endtask

  // Issue one op, then check both results and both latencies.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    bit s1, s4;
    int l1, l4;
    logic [63:0] r1, r4;
    wait_idle(tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    s1 = 0; s4 = 0; l1 = 0; l4 = 0; r1 = '0; r4 = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        in_op = 4'($urandom);
        in_a  = {$urandom, $urandom};
        in_b  = {$urandom, $urandom};
      end
      if (!s1 && out_valid1) begin s1 = 1; l1 = n; r1 = out_result1; end
      if (!s4 && out_valid4) begin s4 = 1; l4 = n; r4 = out_result4; end
      if (s1 && s4) break;
    end
    check({tag, " res k1"}, r1, exp);
    check({tag, " res k4"}, r4, exp);
    check({tag, " lat k1"}, 64'(l1), 64'(exp_lat(op, a, b, 1)));
    check({tag, " lat k4"}, 64'(l4), 64'(exp_lat(op, a, b, 4)));
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_8000_0000;
      4:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [3:0]  ops [13];
  logic [3:0]  rop;
  logic [63:0] ra, rb;
  bit          seen;

  initial begin
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
            OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("rst out_valid", {63'b0, out_valid1 | out_valid4}, 64'd0);
    check("rst busy",      {63'b0, busy1 | busy4}, 64'd0);
    check("rst in_ready",  {63'b0, in_ready1 & in_ready4}, 64'd1);
    check("rst result k1", out_result1, 64'd0);
    check("rst result k4", out_result4, 64'd0);
    rst = 1'b0;

    // Directed arithmetic and boundary cases
    run_op("mul",      OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mulh",     OP_MULH,   '1, '1, 64'h0);
    run_op("mulhu",    OP_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu",   OP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div",      OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem",      OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div0",     OP_DIV,    64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu0",    OP_REMU,   64'd5, 64'd0, 64'd5);
    run_op("div ovf",  OP_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
    run_op("rem ovf",  OP_REM,    64'h8000_0000_0000_0000, '1, 64'h0);
    run_op("mulw",     OP_MULW,   64'h0000_0001_0000_0003, 64'd5, 64'hF);
    run_op("divuw",    OP_DIVUW,  64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divw ovf", OP_DIVW,   64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 12)];
      ra  = rand_opnd();
      rb  = rand_opnd();
      run_op($sformatf("rnd%0d op%h", i, rop), rop, ra, rb, model(rop, ra, rb));
    end

    // Back-pressure: result held while out_ready is low
    wait_idle("hold");
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 64'd1000; in_b = 64'd3; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_a = '1; in_b = '1;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (out_valid1 && out_valid4) seen = 1; else @(negedge clk);
    end
    check("hold seen", {63'b0, seen}, 64'd1);
    for (int n = 0; n < 5; n++) begin
      check("hold res k1",   out_result1, 64'd333);
      check("hold res k4",   out_result4, 64'd333);
      check("hold valid",    {63'b0, out_valid1 & out_valid4}, 64'd1);
      check("hold in_ready", {63'b0, in_ready1 | in_ready4}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post valid",    {63'b0, out_valid1 | out_valid4}, 64'd0);
    check("post in_ready", {63'b0, in_ready1 & in_ready4}, 64'd1);
    check("post retain",   out_result1, 64'd333);

    // Flush at CALC cycle 10
    wait_idle("flush");
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 64'd123456789; in_b = 64'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("flush busy pre", {63'b0, busy1 & busy4}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush busy",     {63'b0, busy1 | busy4}, 64'd0);
    check("flush in_ready", {63'b0, in_ready1 & in_ready4}, 64'd1);
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) seen = 1;
    end
    check("flush no valid", {63'b0, seen}, 64'd0);
    run_op("after flush", OP_DIVU, 64'd100, 64'd7, 64'd14);

    // Flush coinciding with a request accepts nothing
    wait_idle("flush req");
    in_valid = 1'b1; in_op = OP_MUL; in_a = 64'd3; in_b = 64'd4; flush = 1'b1;
    #1;
    check("flush req in_ready", {63'b0, in_ready1 | in_ready4}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush req busy", {63'b0, busy1 | busy4}, 64'd0);

    // Reset in the middle of CALC
    wait_idle("rst mid");
    in_valid = 1'b1; in_op = OP_MUL; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst mid busy pre", {63'b0, busy1 & busy4}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst mid valid",    {63'b0, out_valid1 | out_valid4}, 64'd0);
    check("rst mid busy",     {63'b0, busy1 | busy4}, 64'd0);
    check("rst mid in_ready", {63'b0, in_ready1 & in_ready4}, 64'd1);
    check("rst mid res k1",   out_result1, 64'd0);
    check("rst mid res k4",   out_result4, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide execution unit for the RV32M/RV64M datapath.
- Consumes the 4-bit M-op code produced by the M-extension decoder and the two register operands. Op code is {w_flag, funct3}.
- Produces the rd write-back value after a bounded multi-cycle latency.
- Uses a valid/ready handshake on both sides, so the pipeline stalls while the unit is busy.

Parameters:
- XLEN, 64, datapath width. Legal values: 32, 64. When 32, op[3] is forced to 0 internally.
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration. Legal values: 1, 2, 4; must divide 32.

Ports:
- clk  in  1  clock
- rst  in  1  reset; decided: one clock, reset is synchronous and active-high
- flush  in  1  kill the in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  4  {w, funct3}: 0000 MUL, 0001 MULH, 0010 MULHSU, 0011 MULHU, 0100 DIV, 0101 DIVU, 0110 REM, 0111 REMU, 1000 MULW, 1100 DIVW, 1101 DIVUW, 1110 REMW, 1111 REMUW
- in_a  in  XLEN  rs1 value
- in_b  in  XLEN  rs2 value
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  XLEN  rd value
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE, out_valid 0, out_result 0, busy 0, in_ready 1, iteration counter 0.
- State machine has three states: IDLE, CALC, DONE.
- in_ready = (state == IDLE) && !flush. There is no bypass from DONE to IDLE.
- Accept condition: in_valid && in_ready.
  - Latch op and operands.
  - Compute operand magnitudes and result sign.
  - Set N = 32 for W ops, otherwise XLEN.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - All others: unsigned.
  - W ops use only in_a[31:0] and in_b[31:0]; the signedness of each W op follows its non-W counterpart.
- Multiply:
  - Unsigned shift-add over magnitudes into a 2N-bit product.
  - MUL_BITS_PER_CYCLE bits per CALC cycle, so N/MUL_BITS_PER_CYCLE cycles.
  - Two's-complement negate the full product if the signs differ.
  - MUL and MULW select the low N bits; MULH* select the high N bits.
- Divide:
  - Restoring division, 1 quotient bit per cycle, N CALC cycles, over magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
- Special cases. These are detected in the accept cycle, skip CALC, and enter DONE directly.
  - Divide by zero (b[N-1:0] == 0): quotient = all ones (N bits), remainder = a[N-1:0].
  - Signed overflow (a = most negative N-bit value, b = -1, DIV/REM/DIVW/REMW only): quotient = a, remainder = 0.
- W results: the 32-bit result is sign-extended to XLEN. This applies to all W ops, including DIVUW and REMUW.
- Latency, counting the accept cycle as t:
  - Normal multiply: out_valid rises at t + N/MUL_BITS_PER_CYCLE + 1.
  - Normal divide: out_valid rises at t + N + 1.
  - Special cases: out_valid rises at t + 1.
- Result register:
  - out_result is registered and loaded on entry to DONE.
  - It is held stable while out_valid && !out_ready.
  - It retains its value after the handshake; no clearing is required.
- DONE: out_valid = 1. When out_ready is high, go to IDLE next cycle and drop out_valid.
- flush:
  - From any state, the next state is IDLE and out_valid is 0.
  - A flush coinciding with in_valid accepts nothing.
  - A flush coinciding with an out_ready handshake still just goes to IDLE; the consumer owns that race.
- rst: has priority over flush and all other inputs; any state goes to IDLE.
- Operands in_a, in_b and in_op need only be stable in the accept cycle.

Decomposition:
- mdu_pkg contains:
  - The op encodings, as constants OP_MUL ... OP_REMUW.
  - An enum for the state.
  - Helper functions: sign-extend-32 and negate.
- One natural sub-module is mdu_divider: an iterative restoring core with start/done, parametrised by XLEN, taking magnitudes and a width select.
- The multiplier stays inline in mdu_iter.

Test Plan (XLEN=64 unless noted):
- MUL a=7, b=0xFFFFFFFFFFFFFFFD, MUL_BITS_PER_CYCLE=1: out_result 0xFFFFFFFFFFFFFFEB, out_valid at t+65. With MUL_BITS_PER_CYCLE=4, same result at t+17.
- MULH a=-1, b=-1 gives 0. MULHU a=-1, b=-1 gives 0xFFFFFFFFFFFFFFFE. MULHSU a=-1, b=2 gives 0xFFFFFFFFFFFFFFFF.
- DIV a=-7, b=2 gives 0xFFFFFFFFFFFFFFFD at t+65. REM with the same operands gives 0xFFFFFFFFFFFFFFFF.
- DIV a=5, b=0 gives 0xFFFFFFFFFFFFFFFF; REMU a=5, b=0 gives 5; both at t+1. DIV a=0x8000000000000000, b=-1 gives 0x8000000000000000; REM with the same operands gives 0.
- W ops:
  - MULW a=0x0000000100000003, b=5 gives 0xF.
  - DIVUW a=0xFFFFFFFF, b=1 gives 0xFFFFFFFFFFFFFFFF.
  - DIVW a=0x80000000, b=0xFFFFFFFF (overflow) gives 0xFFFFFFFF80000000 at t+1.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE: out_result stable and in_ready=0 throughout. Then the handshake completes, and in_ready=1 next cycle.
  - Assert flush at CALC cycle 10: next cycle is IDLE, out_valid never rises, and a new DIVU 100/7 then returns 14.
  - rst mid-CALC: all outputs return to their reset values.
